conv2d_unroll_param: RTL
========================

# conv2d_unroll_param

Parametrised K×K convolution engine that computes one output pixel per accepted window using UNROLL parallel multipliers time-multiplexed over TAPS/UNROLL passes. It is the generalised successor of the fixed 3-MAC convolution core. It adds:
- configurable data, accumulator and output widths
- signed/unsigned mode
- valid/ready handshakes on both sides
- per-window output shift, optional ReLU, and saturation with a flag

It sits between the line-buffer/window generator and the feature-map writer.

## Interface
- DATA_W, 8, pixel and weight width
- KSIZE, 3, kernel side; TAPS = KSIZE*KSIZE
- UNROLL, 3, parallel multipliers; TAPS % UNROLL must be 0, otherwise elaboration error; PASSES = TAPS/UNROLL
- ACC_W, 20, accumulator width; must be ≥ 2*DATA_W + clog2(TAPS)
- OUT_W, 16, output width; OUT_W ≤ ACC_W
- SIGNED, 0, 1 = two's-complement pixels, weights and result; 0 = unsigned
- clk  in  1  sole clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  window/kernel/config valid
- in_ready  out  1  block can accept a window this cycle
- win  in  TAPS*DATA_W  window, tap t at bits [t*DATA_W +: DATA_W], row-major
- kern  in  TAPS*DATA_W  weights, same packing
- relu_en  in  1  clamp negative results to 0 (no effect when SIGNED=0)
- shift  in  clog2(ACC_W)  right-shift applied to the accumulator before saturation
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_data  out  OUT_W  result
- out_sat  out  1  result was saturated; qualified by out_valid
- busy  out  1  state != IDLE

## Operation
- States: IDLE, ACCUM, HOLD.
- Accept happens when in_valid && in_ready.
  - win, kern, relu_en and shift are registered; upstream may change them afterwards.
  - Pass counter is set to 0, accumulator cleared, state goes to ACCUM.
- in_ready = (state==IDLE) || (state==HOLD && out_ready). The combinational path from out_ready is permitted.
- ACCUM, pass p (0..PASSES-1): multiply taps p*UNROLL .. p*UNROLL+UNROLL-1 by the matching weights and add all UNROLL products to the accumulator (p=0 loads instead of adding).
- After the last pass the result is post-processed in the same cycle and registered:
  - out_data, out_sat loaded; out_valid set; state goes to HOLD.
- Post-processing order:
  1. Shift the full-width sum right (arithmetic if SIGNED, logical otherwise).
  2. If SIGNED && relu_en, replace a negative value with 0.
  3. Saturate to OUT_W: signed range [-2^(OUT_W-1), 2^(OUT_W-1)-1] or unsigned range [0, 2^OUT_W-1].
  - out_sat=1 iff clamping occurred in step 3. ReLU clamping does not set out_sat.
- Products are 2*DATA_W wide, sign-extended (SIGNED) or zero-extended to ACC_W. The accumulator never wraps under the width rule above.
- HOLD: out_data and out_sat are stable while out_valid && !out_ready.
  - On out_ready: out_valid drops, unless a new window is accepted the same cycle.
  - If a new window is accepted the same cycle, go to ACCUM; otherwise go to IDLE.
- in_valid is ignored whenever in_ready=0.

## Timing
- Reset values: out_valid=0, out_data=0, out_sat=0, busy=0, state=IDLE, in_ready=1 after deassertion. Accumulator, pass counter and input registers are cleared.
- Reset asserted mid-ACCUM or HOLD: the in-flight result is discarded immediately, asynchronously; no out_valid is produced for it.
- Latency: window accepted at edge E gives out_valid=1 after edge E+PASSES.
  - Defaults: 3 cycles. UNROLL=TAPS: 1 cycle. UNROLL=1: 9 cycles for K=3.
- Throughput: one result per PASSES+1 cycles with out_ready held high, because the HOLD→ACCUM overlap costs the one HOLD cycle.
- busy=1 from the edge after accept until the handshake edge that leaves HOLD without a new accept.
- Single pipeline register: no skid buffer, at most one result in flight.

## Test plan
- Defaults, SIGNED=0, all win=1, kern=1..9, shift=0: out_data=45, out_sat=0; out_valid rises 3 cycles after the accept edge; busy and in_ready behave as specified.
- Defaults, all win=kern=255, shift=0: sum 585225, out_data=65535, out_sat=1. Repeat with shift=4: out_data=36576, out_sat=0.
- SIGNED=1, all win=0xFF (-1), kern=2:
  - relu_en=0: out_data=0xFFEE (-18), out_sat=0.
  - relu_en=1: out_data=0, out_sat=0.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid.
  - Required: out_data stable, in_ready=0, a pulsing in_valid is not accepted.
  - Then raise out_ready with in_valid=1 in the same cycle: both handshakes complete, and the second result appears 3 cycles later.
- Parameter sweep UNROLL∈{1,3,9}, KSIZE=3, random signed/unsigned vectors: results match the reference model, and latency is 9/3/1 cycles respectively.
- Deassert rst_n during ACCUM pass 1: out_valid=0 and in_ready=1 immediately after release. The next window (all 2, kern all 3) yields 54 with correct latency.

Source files
------------

// File: rtl/conv2d_unroll_param_if.sv
// Window/result stream bundle for conv2d_unroll_param.
// The master drives windows and accepts results; the engine is the slave.
interface conv2d_unroll_param_if #(
  parameter int DATA_W = 8,
  parameter int KSIZE  = 3,
  parameter int ACC_W  = 20,
  parameter int OUT_W  = 16
);
  localparam int TAPS = KSIZE * KSIZE;
  localparam int SH_W = $clog2(ACC_W);

  logic                   in_valid;
  logic                   in_ready;
  logic [TAPS*DATA_W-1:0] win;
  logic [TAPS*DATA_W-1:0] kern;
  logic                   relu_en;
  logic [SH_W-1:0]        shift;
  logic                   out_valid;
  logic                   out_ready;
  logic [OUT_W-1:0]       out_data;
  logic                   out_sat;

  modport master (
    output in_valid, win, kern, relu_en, shift, out_ready,
    input  in_ready, out_valid, out_data, out_sat
  );

  modport slave (
    input  in_valid, win, kern, relu_en, shift, out_ready,
    output in_ready, out_valid, out_data, out_sat
  );
endinterface

// File: rtl/conv2d_unroll_param.sv
// K x K convolution engine: UNROLL multipliers reused over TAPS/UNROLL passes,
// followed by shift, optional ReLU and saturation to OUT_W.
module conv2d_unroll_param #(
  parameter int DATA_W = 8,
  parameter int KSIZE  = 3,
  parameter int UNROLL = 3,
  parameter int ACC_W  = 20,
  parameter int OUT_W  = 16,
  parameter int SIGNED = 0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  conv2d_unroll_param_if.slave   bus,
  output logic                   busy
);

  localparam int TAPS   = KSIZE * KSIZE;
  localparam int PASSES = TAPS / UNROLL;
  localparam int PC_W   = (PASSES > 1) ? $clog2(PASSES) : 1;
  localparam int SH_W   = $clog2(ACC_W);
  localparam int PR_W   = 2 * DATA_W;

  localparam logic [ACC_W-1:0] UMAX = ACC_W'({OUT_W{1'b1}});
  localparam logic [ACC_W-1:0] SMAX = ACC_W'({(OUT_W-1){1'b1}});
  localparam logic [ACC_W-1:0] SMIN = ~SMAX;

  if (TAPS % UNROLL != 0) begin : g_bad_unroll
    $error("conv2d_unroll_param: TAPS must be a multiple of UNROLL");
  end
  if (ACC_W < PR_W + $clog2(TAPS)) begin : g_bad_acc
    $error("conv2d_unroll_param: ACC_W too narrow for TAPS products");
  end
  if (OUT_W > ACC_W || OUT_W < 2) begin : g_bad_out
    $error("conv2d_unroll_param: OUT_W must be in [2, ACC_W]");
  end

  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

  state_t                 state;
  logic [PC_W-1:0]        pass_cnt;
  logic [ACC_W-1:0]       acc;
  logic [TAPS*DATA_W-1:0] win_q;
  logic [TAPS*DATA_W-1:0] kern_q;
  logic                   relu_q;
  logic [SH_W-1:0]        shift_q;
  logic                   out_valid_q;
  logic [OUT_W-1:0]       out_data_q;
  logic                   out_sat_q;

  logic                   in_ready_c;
  logic                   accept;
  logic [DATA_W-1:0]      pa, pb;
  logic [PR_W-1:0]        ea, eb, prod;
  logic [ACC_W-1:0]       pe;
  logic [ACC_W-1:0]       pass_sum;
  logic [ACC_W-1:0]       acc_next;
  logic [ACC_W-1:0]       shifted;
  logic [ACC_W-1:0]       relu_v;
  logic [OUT_W-1:0]       res_data;
  logic                   res_sat;

  assign in_ready_c = (state == IDLE) || (state == HOLD && bus.out_ready);
  assign accept     = bus.in_valid && in_ready_c;

  // Sum of the UNROLL products for the current pass; each lane muxes its tap by pass index.
  always_comb begin
    pass_sum = '0;
    pa       = '0;
    pb       = '0;
    ea       = '0;
    eb       = '0;
    prod     = '0;
    pe       = '0;
    for (int unsigned u = 0; u < UNROLL; u++) begin
      pa = '0;
      pb = '0;
      for (int unsigned p = 0; p < PASSES; p++) begin
        if (pass_cnt == PC_W'(p)) begin
          pa = win_q[(p*UNROLL+u)*DATA_W +: DATA_W];
          pb = kern_q[(p*UNROLL+u)*DATA_W +: DATA_W];
        end
      end
      if (SIGNED != 0) begin
        ea = PR_W'($signed(pa));
        eb = PR_W'($signed(pb));
      end else begin
        ea = PR_W'(pa);
        eb = PR_W'(pb);
      end
      // Low PR_W bits of the extended product are exact in either mode.
      prod = ea * eb;
      if (SIGNED != 0) pe = ACC_W'($signed(prod));
      else             pe = ACC_W'(prod);
      pass_sum = pass_sum + pe;
    end
  end

  // Accumulate, then shift / ReLU / saturate the would-be final sum.
  always_comb begin
    acc_next = (pass_cnt == '0) ? pass_sum : acc + pass_sum;
    if (SIGNED != 0) shifted = $signed(acc_next) >>> shift_q;
    else             shifted = acc_next >> shift_q;
    relu_v = shifted;
    if (SIGNED != 0 && relu_q && shifted[ACC_W-1]) relu_v = '0;
    res_data = relu_v[OUT_W-1:0];
    res_sat  = 1'b0;
    if (SIGNED != 0) begin
      if ($signed(relu_v) > $signed(SMAX)) begin
        res_data = SMAX[OUT_W-1:0];
        res_sat  = 1'b1;
      end else if ($signed(relu_v) < $signed(SMIN)) begin
        res_data = SMIN[OUT_W-1:0];
        res_sat  = 1'b1;
      end
    end else if (relu_v > UMAX) begin
      res_data = UMAX[OUT_W-1:0];
      res_sat  = 1'b1;
    end
  end

  // Control FSM with input capture and registered result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      pass_cnt    <= '0;
      acc         <= '0;
      win_q       <= '0;
      kern_q      <= '0;
      relu_q      <= 1'b0;
      shift_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sat_q   <= 1'b0;
    end else if (accept) begin
      // Covers both IDLE and the HOLD->ACCUM overlap; the held result is consumed this edge.
      win_q       <= bus.win;
      kern_q      <= bus.kern;
      relu_q      <= bus.relu_en;
      shift_q     <= bus.shift;
      pass_cnt    <= '0;
      acc         <= '0;
      out_valid_q <= 1'b0;
      state       <= ACCUM;
    end else begin
      case (state)
        ACCUM: begin
          acc <= acc_next;
          if (pass_cnt == PC_W'(PASSES - 1)) begin
            out_data_q  <= res_data;
            out_sat_q   <= res_sat;
            out_valid_q <= 1'b1;
            state       <= HOLD;
          end else begin
            pass_cnt <= pass_cnt + 1'b1;
          end
        end
        HOLD: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_sat   = out_sat_q;
  assign busy          = (state != IDLE);

endmodule
